// File: rtl/fifo_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sched_pkg
// Purpose  : Shared types and helpers for the FIFO read-side scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DROP = 2'd2
  } state_e;

  localparam logic SCHED_SP = 1'b0;
  localparam logic SCHED_RR = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rr_arb
// Purpose  : Strict-priority / round-robin arbiter with its own RR pointer.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rr_arb
  import fifo_sched_pkg::*;
#(
  parameter int NUM_Q = 4,
  parameter int IDX_W = clog2(NUM_Q)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NUM_Q-1:0] req_i,
  input  logic             mode_i,
  input  logic             gnt_en_i,
  output logic [NUM_Q-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] sp_idx;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W:0]   rr_j;

  always_comb begin
    sp_idx = '0;
    for (int i = NUM_Q - 1; i >= 0; i--) begin
      if (req_i[i]) sp_idx = IDX_W'(i);
    end
  end

  // Scan offsets from far to near so the first requester after the pointer wins.
  always_comb begin
    rr_idx = '0;
    rr_j   = '0;
    for (int k = NUM_Q; k >= 1; k--) begin
      rr_j = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (rr_j >= (IDX_W+1)'(NUM_Q)) rr_j = rr_j - (IDX_W+1)'(NUM_Q);
      if (req_i[rr_j[IDX_W-1:0]]) rr_idx = rr_j[IDX_W-1:0];
    end
  end

  assign valid_o = |req_i;
  assign idx_o   = (mode_i == SCHED_RR) ? rr_idx : sp_idx;
  assign gnt_o   = valid_o ? (NUM_Q'(1) << idx_o) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_en_i && valid_o) ptr_d = idx_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= IDX_W'(NUM_Q - 1);
    else       ptr_q <= ptr_d;
  end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_sched.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_sched
// Purpose  : Picks one eligible queue and drains one frame into a registered
//            valid/ready stream, truncating frames longer than MAX_BEATS.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_sched
  import fifo_sched_pkg::*;
#(
  parameter int NUM_Q      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BEATS  = 1536,
  parameter int CNT_WIDTH  = 11
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            sched_mode_i,
  input  logic [NUM_Q-1:0]                q_en_i,
  input  logic [NUM_Q-1:0]                q_empty_i,
  input  logic [NUM_Q*(DATA_WIDTH+1)-1:0] q_rdata_i,
  output logic [NUM_Q-1:0]                q_rd_en_o,
  output logic [DATA_WIDTH-1:0]           m_data_o,
  output logic                            m_eop_o,
  output logic                            m_valid_o,
  input  logic                            m_ready_i,
  output logic [NUM_Q-1:0]                grant_o,
  output logic                            busy_o,
  output logic                            trunc_err_o
);

  localparam int IDX_W  = clog2(NUM_Q);
  localparam int WORD_W = DATA_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(MAX_BEATS);

  state_e                state_q, state_d;
  logic [NUM_Q-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]      gidx_q, gidx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  eop_q, eop_d;
  logic                  valid_q, valid_d;
  logic                  trunc_q, trunc_d;
  logic [CNT_WIDTH-1:0]  beat_q, beat_d;

  logic [WORD_W-1:0]     head [NUM_Q];
  logic [NUM_Q-1:0]      elig;
  logic [NUM_Q-1:0]      arb_gnt;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_valid;
  logic                  arb_en;
  logic                  head_empty;
  logic                  head_eop;
  logic                  pop;
  logic                  trunc_hit;
  logic [CNT_WIDTH-1:0]  beat_inc;

  for (genvar k = 0; k < NUM_Q; k++) begin : g_head
    assign head[k] = q_rdata_i[k*WORD_W +: WORD_W];
  end

  assign elig   = q_en_i & ~q_empty_i;
  assign arb_en = (state_q == IDLE) && !rst_i;

  fifo_rr_arb #(
    .NUM_Q (NUM_Q),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (elig),
    .mode_i   (sched_mode_i),
    .gnt_en_i (arb_en),
    .gnt_o    (arb_gnt),
    .idx_o    (arb_idx),
    .valid_o  (arb_valid)
  );

  assign head_empty = q_empty_i[gidx_q];
  assign head_eop   = head[gidx_q][DATA_WIDTH];
  assign beat_inc   = beat_q + 1'b1;
  assign trunc_hit  = !head_eop && (beat_inc == LAST_BEAT);

  // Pop is suppressed while reset is sampled so an abandoned frame stays intact.
  always_comb begin
    pop = 1'b0;
    if (!rst_i) begin
      case (state_q)
        XFER:    pop = !head_empty && (!valid_q || m_ready_i);
        DROP:    pop = !head_empty;
        default: pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (arb_valid) state_d = XFER;
      XFER: begin
        if (pop && head_eop)       state_d = IDLE;
        else if (pop && trunc_hit) state_d = DROP;
      end
      DROP: if (pop && head_eop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    gidx_d  = gidx_q;
    data_d  = data_q;
    eop_d   = eop_q;
    valid_d = valid_q;
    beat_d  = beat_q;
    trunc_d = 1'b0;
    if (valid_q && m_ready_i) valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_gnt;
          gidx_d  = arb_idx;
        end
      end
      XFER: begin
        if (pop) begin
          data_d  = head[gidx_q][DATA_WIDTH-1:0];
          eop_d   = head_eop || trunc_hit;
          valid_d = 1'b1;
          beat_d  = beat_inc;
          trunc_d = trunc_hit;
          if (head_eop) begin
            grant_d = '0;
            beat_d  = '0;
          end
        end
      end
      DROP: begin
        if (pop && head_eop) begin
          grant_d = '0;
          beat_d  = '0;
        end
      end
      default: grant_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_q <= '0;
      gidx_q  <= '0;
      data_q  <= '0;
      eop_q   <= 1'b0;
      valid_q <= 1'b0;
      trunc_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      data_q  <= data_d;
      eop_q   <= eop_d;
      valid_q <= valid_d;
      trunc_q <= trunc_d;
      beat_q  <= beat_d;
    end
  end

  assign q_rd_en_o   = grant_q & {NUM_Q{pop}};
  assign m_data_o    = data_q;
  assign m_eop_o     = eop_q;
  assign m_valid_o   = valid_q;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != IDLE);
  assign trunc_err_o = trunc_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_sched
// Purpose  : Directed self-checking bench for fifo_rd_sched with FIFO models.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_rd_sched;

  localparam int NQ = 4;
  localparam int DW = 8;
  localparam int WW = DW + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            sched_mode;
  logic [NQ-1:0]   q_en;
  logic [NQ-1:0]   q_empty = '1;
  logic [NQ*WW-1:0] q_rdata = '0;
  logic [NQ-1:0]   q_rd_en;
  logic [DW-1:0]   m_data;
  logic            m_eop;
  logic            m_valid;
  logic            m_ready;
  logic [NQ-1:0]   grant;
  logic            busy;
  logic            trunc_err;

  always #5 clk = ~clk;

  fifo_rd_sched #(
    .NUM_Q      (NQ),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (16),
    .CNT_WIDTH  (5)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .sched_mode_i (sched_mode),
    .q_en_i       (q_en),
    .q_empty_i    (q_empty),
    .q_rdata_i    (q_rdata),
    .q_rd_en_o    (q_rd_en),
    .m_data_o     (m_data),
    .m_eop_o      (m_eop),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .grant_o      (grant),
    .busy_o       (busy),
    .trunc_err_o  (trunc_err)
  );

  int checks = 0;
  int errors = 0;

  // FIFO models: pushes are queued by the stimulus and land at the next edge.
  logic [WW-1:0] fifo [NQ][$];
  int            pend_q [$];
  logic [WW-1:0] pend_w [$];
  int            pend_rd = 0;
  int            pops_total = 0;

  always @(posedge clk) begin
    for (int k = 0; k < NQ; k++) begin
      if (q_rd_en[k] && fifo[k].size() > 0) begin
        void'(fifo[k].pop_front());
        pops_total++;
      end
    end
    while (pend_rd < pend_w.size()) begin
      fifo[pend_q[pend_rd]].push_back(pend_w[pend_rd]);
      pend_rd++;
    end
    for (int k = 0; k < NQ; k++) begin
      q_empty[k]            <= (fifo[k].size() == 0);
      q_rdata[k*WW +: WW]   <= (fifo[k].size() > 0) ? fifo[k][0] : '0;
    end
  end

  logic [WW-1:0] out_log [$];
  int            out_cyc [$];
  logic [NQ-1:0] gnt_log [$];
  logic [NQ-1:0] grant_prev = '0;
  logic          stall_prev = 1'b0;
  logic [WW-1:0] held = '0;
  int            stab_viol = 0;
  int            pop_viol = 0;
  int            trunc_cnt = 0;
  int            cyc = 0;
  logic          chk_stall_pop = 1'b0;

  always @(posedge clk) begin
    if (m_valid && m_ready) begin
      out_log.push_back({m_eop, m_data});
      out_cyc.push_back(cyc);
    end
    if (stall_prev && ({m_eop, m_data} !== held)) stab_viol++;
    stall_prev = m_valid && !m_ready;
    held       = {m_eop, m_data};
    if (grant != '0 && grant_prev == '0) gnt_log.push_back(grant);
    grant_prev = grant;
    if (trunc_err) trunc_cnt++;
    if (chk_stall_pop && q_rd_en != '0 && m_valid && !m_ready) pop_viol++;
    cyc++;
  end

  function automatic logic [WW-1:0] mk(input int q, input int n, input bit e);
    logic [DW-1:0] d;
    d = DW'(q * 64 + n);
    return {e, d};
  endfunction

  task automatic push(input int q, input logic [WW-1:0] w);
    pend_q.push_back(q);
    pend_w.push_back(w);
  endtask

  task automatic wait_out(input int n, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (out_log.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    bit empty_all;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      empty_all = (pend_rd == pend_w.size());
      for (int k = 0; k < NQ; k++) if (fifo[k].size() != 0) empty_all = 1'b0;
      if (!busy && !m_valid && empty_all) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=%b", grant, 4'b0000); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (trunc_err !== 1'b0) begin errors++; $display("FAIL reset_trunc got=%b exp=0", trunc_err); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", m_data); end
    checks++; if (m_eop !== 1'b0) begin errors++; $display("FAIL reset_eop got=%b exp=0", m_eop); end
    checks++; if (q_rd_en !== 4'b0000) begin errors++; $display("FAIL reset_rd_en got=%b exp=0000", q_rd_en); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_strict();
    logic [WW-1:0] exp_w [$];
    int ob, gb;
    bit ok;
    ob = out_log.size();
    gb = gnt_log.size();
    sched_mode = 1'b0;
    q_en       = 4'b1111;
    m_ready    = 1'b1;
    push(2, mk(2, 1, 0)); push(2, mk(2, 2, 0)); push(2, mk(2, 3, 1));
    push(1, mk(1, 1, 0)); push(1, mk(1, 2, 1));
    exp_w = '{mk(1, 1, 0), mk(1, 2, 1), mk(2, 1, 0), mk(2, 2, 0), mk(2, 3, 1)};
    wait_out(ob + 5, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sp_timeout got=%0d beats exp=5", out_log.size() - ob); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_log[ob+i] !== exp_w[i]) begin errors++; $display("FAIL sp_word%0d got=%h exp=%h", i, out_log[ob+i], exp_w[i]); end
    end
    checks++; if (gnt_log[gb] !== 4'b0010) begin errors++; $display("FAIL sp_grant0 got=%b exp=0010", gnt_log[gb]); end
    checks++; if (gnt_log[gb+1] !== 4'b0100) begin errors++; $display("FAIL sp_grant1 got=%b exp=0100", gnt_log[gb+1]); end
    checks++; if (out_cyc[ob+2] - out_cyc[ob+1] !== 2) begin errors++; $display("FAIL sp_gap got=%0d exp=2", out_cyc[ob+2] - out_cyc[ob+1]); end
    wait_idle(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sp_idle got=busy%b exp=idle", busy); end
  endtask

  task automatic test_rr();
    int ob, gb;
    bit ok;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ob = out_log.size();
    gb = gnt_log.size();
    sched_mode = 1'b1;
    for (int q = 0; q < NQ; q++) begin
      push(q, mk(q, 1, 1));
      push(q, mk(q, 2, 1));
    end
    wait_out(ob + 8, 120, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_timeout got=%0d beats exp=8", out_log.size() - ob); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (gnt_log[gb+i] !== NQ'(1 << (i % NQ))) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", i, gnt_log[gb+i], NQ'(1 << (i % NQ))); end
      checks++;
      if (out_log[ob+i] !== mk(i % NQ, i / NQ + 1, 1)) begin errors++; $display("FAIL rr_word%0d got=%h exp=%h", i, out_log[ob+i], mk(i % NQ, i / NQ + 1, 1)); end
    end
    wait_idle(40, ok);
  endtask

  task automatic test_backpressure();
    logic rdy_tbl [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int ob, sv0, pv0;
    bit ok;
    ob  = out_log.size();
    sv0 = stab_viol;
    pv0 = pop_viol;
    sched_mode = 1'b0;
    for (int n = 1; n <= 4; n++) push(0, mk(0, n, n == 4));
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL bp_grant got=busy%b exp=busy1", busy); end
    chk_stall_pop = 1'b1;
    for (int i = 0; i < 7; i++) begin
      m_ready = rdy_tbl[i];
      @(negedge clk);
    end
    m_ready = 1'b1;
    wait_out(ob + 4, 40, ok);
    chk_stall_pop = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got=%0d beats exp=4", out_log.size() - ob); end
    wait_idle(40, ok);
    checks++; if (out_log.size() - ob !== 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", out_log.size() - ob); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_log[ob+i] !== mk(0, i + 1, i == 3)) begin errors++; $display("FAIL bp_word%0d got=%h exp=%h", i, out_log[ob+i], mk(0, i + 1, i == 3)); end
    end
    checks++; if (stab_viol - sv0 !== 0) begin errors++; $display("FAIL bp_stable got=%0d exp=0", stab_viol - sv0); end
    checks++; if (pop_viol - pv0 !== 0) begin errors++; $display("FAIL bp_pop_stall got=%0d exp=0", pop_viol - pv0); end
  endtask

  task automatic test_truncation();
    int ob, tc0;
    bit ok;
    ob  = out_log.size();
    tc0 = trunc_cnt;
    for (int n = 1; n <= 20; n++) push(0, mk(0, n, n == 20));
    wait_out(ob + 16, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tr_timeout got=%0d beats exp=16", out_log.size() - ob); end
    wait_idle(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tr_idle got=busy%b left=%0d exp=idle", busy, fifo[0].size()); end
    checks++; if (out_log.size() - ob !== 16) begin errors++; $display("FAIL tr_count got=%0d exp=16", out_log.size() - ob); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_log[ob+i] !== mk(0, i + 1, i == 15)) begin errors++; $display("FAIL tr_word%0d got=%h exp=%h", i, out_log[ob+i], mk(0, i + 1, i == 15)); end
    end
    checks++; if (trunc_cnt - tc0 !== 1) begin errors++; $display("FAIL tr_pulses got=%0d exp=1", trunc_cnt - tc0); end
    checks++; if (fifo[0].size() !== 0) begin errors++; $display("FAIL tr_drained got=%0d exp=0", fifo[0].size()); end
  endtask

  task automatic test_underflow();
    int ob, gb;
    bit ok;
    ob = out_log.size();
    gb = gnt_log.size();
    push(3, mk(3, 1, 0));
    push(3, mk(3, 2, 0));
    repeat (3) @(negedge clk);
    q_en = 4'b0111;
    repeat (7) @(negedge clk);
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL uf_grant_hold got=%b exp=1000", grant); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL uf_busy got=%b exp=1", busy); end
    checks++; if (out_log.size() - ob !== 2) begin errors++; $display("FAIL uf_paused got=%0d exp=2", out_log.size() - ob); end
    push(3, mk(3, 3, 0));
    push(3, mk(3, 4, 0));
    push(3, mk(3, 5, 1));
    wait_out(ob + 5, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL uf_timeout got=%0d beats exp=5", out_log.size() - ob); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_log[ob+i] !== mk(3, i + 1, i == 4)) begin errors++; $display("FAIL uf_word%0d got=%h exp=%h", i, out_log[ob+i], mk(3, i + 1, i == 4)); end
    end
    wait_idle(40, ok);
    checks++; if (gnt_log.size() - gb !== 1) begin errors++; $display("FAIL uf_grants got=%0d exp=1", gnt_log.size() - gb); end
    checks++; if (gnt_log[gb] !== 4'b1000) begin errors++; $display("FAIL uf_grant got=%b exp=1000", gnt_log[gb]); end
    q_en = 4'b1111;
  endtask

  task automatic test_reset_mid();
    int ob, gb, pb;
    bit ok;
    ob = out_log.size();
    gb = gnt_log.size();
    pb = pops_total;
    sched_mode = 1'b1;
    for (int n = 1; n <= 6; n++) push(1, mk(1, n, n == 6));
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pops_total - pb >= 2) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rm_pops got=%0d exp=2", pops_total - pb); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rm_grant got=%b exp=0000", grant); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got=%b exp=0", m_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%b exp=0", busy); end
    checks++; if (fifo[1].size() !== 4) begin errors++; $display("FAIL rm_left got=%0d exp=4", fifo[1].size()); end
    rst = 1'b0;
    wait_out(ob + 6, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_timeout got=%0d beats exp=6", out_log.size() - ob); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_log[ob+i] !== mk(1, i + 1, i == 5)) begin errors++; $display("FAIL rm_word%0d got=%h exp=%h", i, out_log[ob+i], mk(1, i + 1, i == 5)); end
    end
    checks++; if (gnt_log[gb+1] !== 4'b0010) begin errors++; $display("FAIL rm_regrant got=%b exp=0010", gnt_log[gb+1]); end
    wait_idle(40, ok);
  endtask

  initial begin
    rst        = 1'b1;
    sched_mode = 1'b0;
    q_en       = 4'b1111;
    m_ready    = 1'b1;
    test_reset();
    test_strict();
    test_rr();
    test_backpressure();
    test_truncation();
    test_underflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
